// File: rtl/iic_pkg.sv
// iic_pkg: shared types and constants for the codec I2C target
package iic_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_A, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, WAIT_STOP, IGNORE
   } iic_tgt_state_t;
   localparam logic [6:0] IIC_CODEC_ADDR = 7'b0011010;
   localparam int IIC_WORD_W = 16;
   localparam int IIC_BITS = 8;
   localparam int IIC_ACK_SLOT = 9;
   // data state that follows each acknowledge slot
   function automatic iic_tgt_state_t after_ack(input iic_tgt_state_t s);
      return s == ACK_A ? BYTE_HI : s == ACK_HI ? BYTE_LO : WAIT_STOP;
   endfunction
endpackage

// File: rtl/iic_line_sync.sv
// iic_line_sync: bus line synchronizer, optional stability filter (IIC_TARGET_GLITCH_FILTER_EN), edge detect
module iic_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   // resync chain; resets to the idle-high bus level
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '1;
      else sync <= {sync[SYNC_STAGES-2:0], din};
`ifdef IIC_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic held;
   assign level = (hist == {2{sync[SYNC_STAGES-1]}}) ? sync[SYNC_STAGES-1] : held;
   // last two synchronized samples plus the held output for the 3-agree filter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hist <= '1;
         held <= 1'b1;
      end else begin
         hist <= {hist[0], sync[SYNC_STAGES-1]};
         held <= level;
      end
`else
   assign level = sync[SYNC_STAGES-1];
`endif
   // history flop for edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) prev <= 1'b1;
      else prev <= level;
   assign rise = level & ~prev;
   assign fall = ~level & prev;
endmodule

// File: rtl/iic_codec_target.sv
// iic_codec_target: I2C write-only target capturing {reg[6:0], data[8:0]} codec frames
module iic_codec_target
   import iic_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = IIC_CODEC_ADDR,
   parameter int SYNC_STAGES = 2
) (
   input  logic MCLK,
   input  logic RESET,
   input  logic SCL_IN,
   input  logic SDA_IN,
   output logic SDA_OE,
   output logic [IIC_WORD_W-1:0] RX_DATA,
   output logic RX_VALID,
   output logic RX_ERROR,
   output logic BUSY
);
   iic_tgt_state_t state, state_n;
   logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
   logic [7:0] sh, sh_n, byte_in;
   logic [2:0] cnt, cnt_n;
   logic got8, got8_n, extra, extra_n, oe_n, valid_n, error_n, busy_n, last, start, stop;
   logic [IIC_WORD_W-1:0] word, word_n, data_n;
   iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
      .clk(MCLK), .rst(RESET), .din(SCL_IN), .level(scl), .rise(scl_rise), .fall(scl_fall)
   );
   iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
      .clk(MCLK), .rst(RESET), .din(SDA_IN), .level(sda), .rise(sda_rise), .fall(sda_fall)
   );
   assign start = sda_fall & scl;
   assign stop = sda_rise & scl;
   assign byte_in = {sh[6:0], sda};
   assign last = cnt == 3'(IIC_BITS - 1);
   // state and datapath register; async reset releases SDA at once
   always_ff @(posedge MCLK or posedge RESET)
      if (RESET) begin
         state <= IDLE;
         sh <= '0;
         cnt <= '0;
         got8 <= 1'b0;
         extra <= 1'b0;
         word <= '0;
         SDA_OE <= 1'b0;
         RX_DATA <= '0;
         RX_VALID <= 1'b0;
         RX_ERROR <= 1'b0;
         BUSY <= 1'b0;
      end else begin
         state <= state_n;
         sh <= sh_n;
         cnt <= cnt_n;
         got8 <= got8_n;
         extra <= extra_n;
         word <= word_n;
         SDA_OE <= oe_n;
         RX_DATA <= data_n;
         RX_VALID <= valid_n;
         RX_ERROR <= error_n;
         BUSY <= busy_n;
      end
   // bus event decode: START/STOP override, SCL rise samples, SCL fall drives ACK
   always_comb begin
      state_n = state;
      sh_n = sh;
      cnt_n = cnt;
      got8_n = got8;
      extra_n = extra;
      word_n = word;
      oe_n = SDA_OE;
      data_n = RX_DATA;
      valid_n = 1'b0;
      error_n = 1'b0;
      busy_n = BUSY;
      if (start) begin
         state_n = ADDR;
         cnt_n = '0;
         got8_n = 1'b0;
         extra_n = 1'b0;
         oe_n = 1'b0;
         busy_n = 1'b0;
      end else if (stop) begin
         state_n = IDLE;
         got8_n = 1'b0;
         oe_n = 1'b0;
         busy_n = 1'b0;
         valid_n = BUSY && state == WAIT_STOP && !extra;
         error_n = BUSY && !valid_n;
         data_n = valid_n ? word : RX_DATA;
      end else begin
         case (state)
            ADDR, BYTE_HI, BYTE_LO:
               if (scl_rise && !got8) begin
                  sh_n = byte_in;
                  cnt_n = cnt + 3'd1;
                  if (last) begin
                     got8_n = 1'b1;
                     if (state == ADDR) begin
                        if (byte_in == {DEV_ADDR, 1'b0}) busy_n = 1'b1;
                        else state_n = IGNORE;
                     end else if (state == BYTE_HI) word_n[15:8] = byte_in;
                     else word_n[7:0] = byte_in;
                  end
               end else if (scl_fall && got8) begin
                  got8_n = 1'b0;
                  oe_n = 1'b1;
                  state_n = state == ADDR ? ACK_A : state == BYTE_HI ? ACK_HI : ACK_LO;
               end
            ACK_A, ACK_HI, ACK_LO:
               if (scl_fall) begin
                  oe_n = 1'b0;
                  cnt_n = '0;
                  state_n = after_ack(state);
               end
            WAIT_STOP:
               if (scl_fall) extra_n = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/iic_codec_target.md
Name: iic_codec_target

Overview:
- I2C target (responder) that receives the codec register-write frames our I2C master produces: address byte, then two data bytes.
- Acknowledges frames addressed to DEV_ADDR with R/W=0, then presents the 16-bit word {register address[6:0], data[8:0]} with a one-cycle strobe.
- Serves as the codec-side model in system benches and as an on-FPGA register sink for soft codec blocks.
- Runs entirely in the MCLK domain and oversamples the bus lines.

Parameters:
- DEV_ADDR, 7'b0011010, 7-bit target address to match.
- SYNC_STAGES, 2, flip-flop stages on the SCL_IN and SDA_IN synchronizers (minimum 2).

Ports:
- MCLK  input  1  system clock; must be at least 8x the SCL rate.
- RESET  input  1  asynchronous, active-high reset.
- SCL_IN  input  1  bus clock line, raw from pad.
- SDA_IN  input  1  bus data line, raw from pad.
- SDA_OE  output  1  1 = pull SDA low (open-drain); 0 = release.
- RX_DATA  output  16  last completed word, MSB first.
- RX_VALID  output  1  one-MCLK pulse when RX_DATA updates.
- RX_ERROR  output  1  one-MCLK pulse when an addressed frame is malformed.
- BUSY  output  1  high from a matching address until STOP or abort.

Behaviour:
- Reset (async, any state): SDA_OE=0, RX_DATA=0, RX_VALID=0, RX_ERROR=0, BUSY=0, state IDLE, shift register and bit counter cleared. Reset mid-ACK releases SDA immediately.
- Line conditioning:
  - SCL_IN and SDA_IN each pass through SYNC_STAGES flip-flops, then one history flop for edge detection.
  - All events are decoded from the synchronized values.
- Events:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise samples data; SCL fall changes SDA_OE.
- States: IDLE, ADDR, ACK_A, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, WAIT_STOP, IGNORE.
- START from any state (including repeated START) -> ADDR; bit counter=0; SDA_OE=0.
- ADDR / BYTE_HI / BYTE_LO:
  - Shift SDA into an 8-bit register, MSB first, on each SCL rise; 3-bit counter.
  - After the 8th rise, the next SCL fall enters the ACK state and sets SDA_OE=1.
- ACK_x: SDA_OE=1 held through the 9th clock. The following SCL fall clears SDA_OE and advances to the next data state; after ACK_LO it advances to WAIT_STOP.
- Address check happens on the 8th SCL rise of ADDR:
  - Mismatch or R/W=1 -> IGNORE; SDA_OE stays 0, BUSY stays 0.
  - Match -> BUSY=1.
- IGNORE: no drive; exits only on START, STOP or reset.
- WAIT_STOP:
  - STOP -> RX_DATA={hi,lo}, RX_VALID=1 for one cycle, BUSY=0, then IDLE.
  - Any further byte clocks are not acknowledged; the subsequent STOP gives RX_ERROR instead of RX_VALID.
- STOP in ADDR, ACK_x, BYTE_HI or BYTE_LO (after an address match): RX_ERROR pulse, RX_DATA unchanged, BUSY=0, IDLE. STOP in IDLE or IGNORE is silent.
- Latency: STOP at the pins -> RX_VALID after SYNC_STAGES+1 MCLK cycles. SCL fall at the pins -> SDA_OE change after SYNC_STAGES+1 cycles.
- RX_VALID and RX_ERROR are mutually exclusive and never asserted in consecutive cycles from the same frame.
- No clock stretching; SCL is never driven.

Optional Feature:
- Macro: IIC_TARGET_GLITCH_FILTER_EN.
- Defined: after synchronization, each line passes a 3-sample stability filter; the filtered output changes only when 3 consecutive samples agree. Adds 2 MCLK cycles to every latency above. Single-cycle pulses on SCL/SDA are rejected.
- Undefined: synchronized values are used directly.

Decomposition:
- Package iic_pkg holds:
  - state enum iic_tgt_state_t;
  - constant IIC_CODEC_ADDR = 7'b0011010;
  - constant IIC_WORD_W = 16;
  - localparams for bit count 8 and ACK slot 9.
- One sub-module, iic_line_sync: synchronizer, optional glitch filter, history flop; outputs level, rise and fall. Instantiated once for SCL and once for SDA.

Test Plan:
- Write frame addr 0x1A+W (byte 0x34), 0x12, 0x34, STOP -> ACK low on all three 9th clocks; RX_VALID one cycle; RX_DATA=16'h1234; RX_ERROR=0.
- Address byte 0x36 (0x1B+W) then two bytes -> SDA_OE never 1; no RX_VALID; BUSY stays 0.
- Address byte 0x35 (0x1A+R) -> no ACK; state IGNORE until STOP; no pulses.
- Addr 0x34, byte 0x0E, STOP -> two ACKs, then RX_ERROR pulse; RX_DATA holds its previous value.
- Addr 0x34, byte 0xFF, repeated START, addr 0x34, 0x0E, 0x42, STOP -> RX_VALID with RX_DATA=16'h0E42.
- RESET asserted during ACK_HI (SDA_OE=1) -> SDA_OE=0 and BUSY=0 in the same cycle; next full frame 0x1234 is received correctly.
